frame_rr_arbiter: RTL and testbench



---
 rtl/frame_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_frame_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: grants one channel FIFO per frame, repairs broken
// framing (pre-header junk, lost footer, length overrun) and forwards over a registered valid/ready port.
module frame_rr_arbiter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned MAX_FRAME_WORDS = 256
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DIN,
    input  logic [NUM_CH-1:0]            CH_READ_REQUEST,
    output logic [NUM_CH-1:0]            CH_RE,
    input  logic                         iREADY,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic                         oVALID,
    output logic [NUM_CH-1:0]            GRANT,
    output logic [15:0]                  DROP_CNT,
    output logic [15:0]                  TRUNC_CNT
);

    localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WCW    = $clog2(MAX_FRAME_WORDS);
    localparam int unsigned FILL_W = 4 * ((DATA_WIDTH + 3) / 4);
    localparam logic [FILL_W-1:0]     FILL_E   = {((DATA_WIDTH + 3) / 4){4'hE}};
    localparam logic [DATA_WIDTH-1:0] RST_DOUT = FILL_E[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SYN_FTR  = {{(DATA_WIDTH-16){1'b0}}, 16'h55EE};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_SEND
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_last;
    logic [CW-1:0]         r_gidx;
    logic [NUM_CH-1:0]     r_grant;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic [WCW-1:0]        r_wcnt;
    logic [15:0]           r_drop;
    logic [15:0]           r_trunc;

    logic [DATA_WIDTH-1:0] w_gdin;
    logic                  w_greq;
    logic                  w_space;
    logic                  w_hdr;
    logic                  w_ftr;
    logic                  w_pop;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_ldata;
    logic                  w_drop_inc;
    logic                  w_trunc_inc;
    logic [WCW-1:0]        w_wcnt_nxt;
    logic                  w_arb_hit;
    logic [CW-1:0]         w_arb_idx;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned off);
        return CW'((32'(base) + off) % NUM_CH);
    endfunction

    assign w_gdin  = CH_DIN[32'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_greq  = CH_READ_REQUEST[r_gidx];
    assign w_space = !r_valid || iREADY;
    assign w_hdr   = (w_gdin[DATA_WIDTH-1 -: 16] == 16'hAAAA) || (w_gdin[DATA_WIDTH-1 -: 16] == 16'hAAEE);
    assign w_ftr   = (w_gdin[15:0] == 16'h5555) || (w_gdin[15:0] == 16'h55EE);

    // Search starts one past the last owner so every requester is reached within NUM_CH grants.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            if (!w_arb_hit && CH_READ_REQUEST[rr_idx(r_last, i)]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = rr_idx(r_last, i);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_ldata     = w_gdin;
        w_drop_inc  = 1'b0;
        w_trunc_inc = 1'b0;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) w_next = ST_SEEK;
            end
            ST_SEEK: begin
                if (w_greq) begin
                    if (!w_hdr) begin
                        w_pop      = 1'b1;
                        w_drop_inc = 1'b1;
                    end else if (w_space) begin
                        w_pop      = 1'b1;
                        w_load     = 1'b1;
                        w_wcnt_nxt = WCW'(1);
                        w_next     = w_ftr ? ST_IDLE : ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (w_greq && w_space) begin
                    // A new header means the footer was lost: close without consuming it.
                    if (w_hdr) begin
                        w_load      = 1'b1;
                        w_ldata     = SYN_FTR;
                        w_trunc_inc = 1'b1;
                        w_next      = ST_IDLE;
                    end else if (w_ftr) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                        w_next = ST_IDLE;
                    end else if (r_wcnt == WCW'(MAX_FRAME_WORDS - 1)) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_ldata     = {w_gdin[DATA_WIDTH-1:16], 16'h55EE};
                        w_trunc_inc = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_pop      = 1'b1;
                        w_load     = 1'b1;
                        w_wcnt_nxt = r_wcnt + WCW'(1);
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
            r_last  <= CW'(NUM_CH - 1);
            r_gidx  <= '0;
            r_grant <= '0;
            r_dout  <= RST_DOUT;
            r_valid <= 1'b0;
            r_wcnt  <= '0;
            r_drop  <= '0;
            r_trunc <= '0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_nxt;
            if (r_state == ST_IDLE && w_arb_hit) begin
                r_gidx  <= w_arb_idx;
                r_last  <= w_arb_idx;
                r_grant <= NUM_CH'(1) << w_arb_idx;
            end else if (r_state != ST_IDLE && w_next == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_load) begin
                r_dout  <= w_ldata;
                r_valid <= 1'b1;
            end else if (iREADY) begin
                r_valid <= 1'b0;
            end
            if (w_drop_inc && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            if (w_trunc_inc && r_trunc != 16'hFFFF) r_trunc <= r_trunc + 16'd1;
        end
    end

    assign CH_RE     = w_pop ? (NUM_CH'(1) << r_gidx) : '0;
    assign GRANT     = r_grant;
    assign DOUT      = r_dout;
    assign oVALID    = r_valid;
    assign DROP_CNT  = r_drop;
    assign TRUNC_CNT = r_trunc;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Scoreboard bench for frame_rr_arbiter: FWFT channel FIFO models feed the DUT,
// expected words are queued at stimulus time and popped by an independent output monitor.
module tb_frame_rr_arbiter;

    localparam int DW  = 64;
    localparam int NCH = 2;

    logic              CLK    = 1'b0;
    logic              RESETN = 1'b0;
    logic              iREADY = 1'b1;
    logic [NCH*DW-1:0] CH_DIN;
    logic [NCH-1:0]    CH_READ_REQUEST;
    logic [NCH-1:0]    CH_RE;
    logic [NCH-1:0]    GRANT;
    logic [DW-1:0]     DOUT;
    logic              oVALID;
    logic [15:0]       DROP_CNT;
    logic [15:0]       TRUNC_CNT;

    logic [63:0] mem [NCH][128];
    logic [6:0]  wr_ptr [NCH];
    logic [6:0]  rd_ptr [NCH];
    logic [63:0] exp_q [$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          out_cnt = 0;

    always #5 CLK = ~CLK;

    frame_rr_arbiter #(
        .DATA_WIDTH      (DW),
        .NUM_CH          (NCH),
        .MAX_FRAME_WORDS (4)
    ) dut (
        .CLK             (CLK),
        .RESETN          (RESETN),
        .CH_DIN          (CH_DIN),
        .CH_READ_REQUEST (CH_READ_REQUEST),
        .CH_RE           (CH_RE),
        .iREADY          (iREADY),
        .DOUT            (DOUT),
        .oVALID          (oVALID),
        .GRANT           (GRANT),
        .DROP_CNT        (DROP_CNT),
        .TRUNC_CNT       (TRUNC_CNT)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_fifo
        assign CH_READ_REQUEST[k] = (rd_ptr[k] != wr_ptr[k]);
        assign CH_DIN[k*DW +: DW] = mem[k][rd_ptr[k]];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, req);
    endtask

    // FIFO read side: CH_RE is stable from the falling edge to the next rising edge.
    initial begin
        logic [NCH-1:0] re_s;
        for (int k = 0; k < NCH; k++) rd_ptr[k] = '0;
        forever begin
            @(negedge CLK);
            re_s = CH_RE;
            @(posedge CLK);
            if (RESETN) begin
                #1;
                for (int k = 0; k < NCH; k++)
                    if (re_s[k]) rd_ptr[k] = rd_ptr[k] + 7'd1;
            end
        end
    end

    // Output monitor
    initial begin
        logic        pv;
        logic        pr;
        logic [63:0] pd;
        logic [63:0] e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge CLK);
            if (!RESETN) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", oVALID, 1);
                    check("hold_dout", DOUT, pd);
                end
                if (CH_RE != '0) begin
                    check("re_legal", CH_RE & ~CH_READ_REQUEST, 0);
                    check("re_onehot", $onehot(CH_RE), 1);
                end
                if (oVALID && iREADY) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_unexpected: actual=%h required=none", DOUT);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_word", DOUT, e);
                    end
                    out_cnt++;
                end
                pv = oVALID;
                pr = iREADY;
                pd = DOUT;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic push(input int ch, input logic [63:0] w);
        mem[ch][wr_ptr[ch]] = w;
        wr_ptr[ch] = wr_ptr[ch] + 7'd1;
    endtask

    task automatic expect_word(input logic [63:0] w);
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
        check(nm, exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic wait_grant(input logic [NCH-1:0] g, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK);
            if (GRANT == g) ok = 1'b1;
        end
        check(nm, GRANT, g);
    endtask

    initial begin
        logic [11:0] pat;
        int          target;
        bit          ok;
        for (int k = 0; k < NCH; k++) wr_ptr[k] = '0;
        RESETN = 1'b0;
        iREADY = 1'b1;
        step();
        check("rst_valid", oVALID, 0);
        check("rst_dout", DOUT, 64'hEEEE_EEEE_EEEE_EEEE);
        check("rst_grant", GRANT, 0);
        check("rst_re", CH_RE, 0);
        check("rst_drop", DROP_CNT, 0);
        check("rst_trunc", TRUNC_CNT, 0);
        step();
        RESETN = 1'b1;
        step();

        // 1: two competing frames, channel 0 first, 2-cycle first-word latency
        push(0, 64'hAAAA_0000_0000_0001); push(0, 64'h2); push(0, 64'h5555);
        push(1, 64'hAAAA_0000_0000_0011); push(1, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0001); expect_word(64'h2); expect_word(64'h5555);
        expect_word(64'hAAAA_0000_0000_0011); expect_word(64'h5555);
        @(negedge CLK); check("t1_lat_c0", oVALID, 0);
        @(negedge CLK); check("t1_lat_c1", oVALID, 0); check("t1_grant0", GRANT, 2'b01);
        @(negedge CLK); check("t1_lat_c2", oVALID, 1);
        wait_grant(2'b10, "t1_grant1");
        drain("t1_drain");

        // 2: junk before the header is dropped
        push(1, 64'h1234); push(1, 64'h1234);
        push(1, 64'hAAAA_0000_0000_0000); push(1, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0000); expect_word(64'h5555);
        drain("t2_drain");
        check("t2_drop", DROP_CNT, 2);

        // 3: lost footer closed with a synthetic footer, new header kept
        push(0, 64'hAAAA_0000_0000_0001); push(0, 64'h2);
        push(0, 64'hAAAA_0000_0000_0003); push(0, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0001); expect_word(64'h2); expect_word(64'h55EE);
        expect_word(64'hAAAA_0000_0000_0003); expect_word(64'h5555);
        drain("t3_drain");
        check("t3_trunc", TRUNC_CNT, 1);
        check("t3_drop", DROP_CNT, 2);

        // 4: length overrun at 4 words, tail dropped on the next grant
        push(0, 64'hAAAA_0000_0000_0040);
        for (int i = 1; i <= 6; i++) push(0, 64'h1111_0000_0000_0040 + 64'(i));
        expect_word(64'hAAAA_0000_0000_0040);
        expect_word(64'h1111_0000_0000_0041);
        expect_word(64'h1111_0000_0000_0042);
        expect_word(64'h1111_0000_0000_55EE);
        drain("t4_drain");
        repeat (10) step();
        check("t4_trunc", TRUNC_CNT, 2);
        check("t4_drop", DROP_CNT, 5);
        check("t4_grant_held", GRANT, 2'b01);

        // 5: backpressure during a full-length frame ending in a real footer
        push(0, 64'hAAAA_0000_0000_0050); push(0, 64'h51); push(0, 64'h52); push(0, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0050); expect_word(64'h51);
        expect_word(64'h52); expect_word(64'h5555);
        pat = 12'b1011_0010_1001;
        for (int i = 0; i < 12; i++) begin
            iREADY = pat[i];
            step();
        end
        iREADY = 1'b1;
        drain("t5_drain");
        check("t5_trunc", TRUNC_CNT, 2);

        // 6: asynchronous reset mid-frame
        push(0, 64'hAAAA_0000_0000_0060); push(0, 64'h61); push(0, 64'h62); push(0, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0060); expect_word(64'h61);
        target = out_cnt + 2;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge CLK);
            #2;
            if (out_cnt >= target) ok = 1'b1;
        end
        check("t6_reach", out_cnt, target);
        RESETN = 1'b0;
        #1;
        check("t6_valid", oVALID, 0);
        check("t6_grant", GRANT, 0);
        check("t6_re", CH_RE, 0);
        check("t6_dout", DOUT, 64'hEEEE_EEEE_EEEE_EEEE);
        check("t6_drop_rst", DROP_CNT, 0);
        check("t6_trunc_rst", TRUNC_CNT, 0);
        step();
        push(0, 64'hAAAA_0000_0000_0070); push(0, 64'h5555);
        push(1, 64'hAAAA_0000_0000_0071); push(1, 64'h5555);
        expect_word(64'hAAAA_0000_0000_0070); expect_word(64'h5555);
        expect_word(64'hAAAA_0000_0000_0071); expect_word(64'h5555);
        RESETN = 1'b1;
        drain("t6_drain");
        check("t6_drop", DROP_CNT, 2);
        check("t6_trunc", TRUNC_CNT, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
